// File: rtl/alu_pkg.sv
// Shared constants, ALU select encodings and sequencer state type for the
// ALU command sequencer and the ALU it feeds.
package alu_pkg;

   localparam int WIDTH = 8;
   localparam int SEL_W = 4;
   localparam logic [3:0] HDR = 4'hA;

   localparam logic [SEL_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [SEL_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [SEL_W-1:0] ALU_AND   = 4'd2;
   localparam logic [SEL_W-1:0] ALU_OR    = 4'd3;
   localparam logic [SEL_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [SEL_W-1:0] ALU_NOT   = 4'd5;
   localparam logic [SEL_W-1:0] ALU_SHL   = 4'd6;
   localparam logic [SEL_W-1:0] ALU_SHR   = 4'd7;
   localparam logic [SEL_W-1:0] ALU_INC   = 4'd8;
   localparam logic [SEL_W-1:0] ALU_DEC   = 4'd9;
   localparam logic [SEL_W-1:0] ALU_PASSA = 4'd10;
   localparam logic [SEL_W-1:0] ALU_PASSB = 4'd11;
   localparam logic [SEL_W-1:0] ALU_NAND  = 4'd12;
   localparam logic [SEL_W-1:0] ALU_NOR   = 4'd13;
   localparam logic [SEL_W-1:0] ALU_XNOR  = 4'd14;
   localparam logic [SEL_W-1:0] ALU_ROL   = 4'd15;

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_A    = 3'd1,
      S_B    = 3'd2,
      S_WAIT = 3'd3,
      S_RES  = 3'd4
   } state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Byte input stream, ALU operand/result bus and tagged result stream of the
// sequencer. The slave modport is the sequencer's view; master is the
// environment (feeder, ALU and result consumer).
interface alu_cmd_sequencer_if;
   import alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [SEL_W-1:0] alu_sel;
   logic [WIDTH-1:0] alu_out;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;
   logic [SEL_W-1:0] res_sel;
   logic             err_hdr;
   logic [7:0]       err_count;
   logic             busy;

   modport slave (
      input  in_valid, in_data, alu_out, res_ready,
      output in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
             err_hdr, err_count, busy
   );

   modport master (
      output in_valid, in_data, alu_out, res_ready,
      input  in_ready, alu_a, alu_b, alu_sel, res_valid, res_data, res_sel,
             err_hdr, err_count, busy
   );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Collects 3-byte command frames, drives them onto the ALU, waits out the
// ALU latency and hands the opcode-tagged result downstream.
//
// state  | meaning
// S_HDR  | waiting for header byte (upper nibble must equal HDR)
// S_A    | waiting for operand A
// S_B    | waiting for operand B; accept edge launches the ALU operation
// S_WAIT | counting down ALU latency, captures alu_out at terminal count
// S_RES  | result presented, held until res_ready
module alu_cmd_sequencer
   import alu_pkg::*;
#(
   parameter int ALU_LAT = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   alu_cmd_sequencer_if.slave   bus
);

   localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [SEL_W-1:0] r_op_pend;
   logic [WIDTH-1:0] r_a_pend;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;
   logic [SEL_W-1:0] r_alu_sel;
   logic [WIDTH-1:0] r_res_data;
   logic [SEL_W-1:0] r_res_sel;
   logic             r_err_hdr;
   logic [7:0]       r_err_count;
   logic [CNT_W-1:0] r_wait_cnt;

   logic w_in_ready;
   logic w_xfer;
   logic w_hdr_ok;
   logic w_wait_done;

   // in_ready is forced low combinationally while reset is held
   assign w_in_ready  = !reset && (r_state == S_HDR || r_state == S_A || r_state == S_B);
   assign w_xfer      = bus.in_valid && w_in_ready;
   assign w_hdr_ok    = (bus.in_data[WIDTH-1 -: 4] == HDR);
   assign w_wait_done = (r_wait_cnt == '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_HDR;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_HDR:   if (w_xfer && w_hdr_ok) w_state_nxt = S_A;
         S_A:     if (w_xfer) w_state_nxt = S_B;
         S_B:     if (w_xfer) w_state_nxt = S_WAIT;
         S_WAIT:  if (w_wait_done) w_state_nxt = S_RES;
         S_RES:   if (bus.res_ready) w_state_nxt = S_HDR;
         default: w_state_nxt = S_HDR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op_pend   <= '0;
         r_a_pend    <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_alu_sel   <= '0;
         r_res_data  <= '0;
         r_res_sel   <= '0;
         r_err_hdr   <= 1'b0;
         r_err_count <= '0;
         r_wait_cnt  <= '0;
      end else begin
         r_err_hdr <= (r_state == S_HDR) && w_xfer && !w_hdr_ok;
         case (r_state)
            S_HDR: begin
               if (w_xfer && w_hdr_ok) r_op_pend <= bus.in_data[SEL_W-1:0];
               if (w_xfer && !w_hdr_ok && r_err_count != 8'hFF)
                  r_err_count <= r_err_count + 8'd1;
            end
            S_A: if (w_xfer) r_a_pend <= bus.in_data;
            S_B: if (w_xfer) begin
               r_alu_a    <= r_a_pend;
               r_alu_b    <= bus.in_data;
               r_alu_sel  <= r_op_pend;
               r_res_sel  <= r_op_pend;
               r_wait_cnt <= CNT_LOAD;
            end
            S_WAIT: begin
               if (w_wait_done) r_res_data <= bus.alu_out;
               else             r_wait_cnt <= r_wait_cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.alu_sel   = r_alu_sel;
   assign bus.res_valid = (r_state == S_RES);
   assign bus.res_data  = r_res_data;
   assign bus.res_sel   = r_res_sel;
   assign bus.err_hdr   = r_err_hdr;
   assign bus.err_count = r_err_count;
   assign bus.busy      = (r_state != S_HDR);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a registered stub ALU.
module tb_alu_cmd_sequencer;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   alu_cmd_sequencer_if bus();

   alu_cmd_sequencer #(.ALU_LAT(1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Registered stub ALU: one clock of latency
   always_ff @(posedge clk) begin
      case (bus.alu_sel)
         ALU_ADD:   bus.alu_out <= bus.alu_a + bus.alu_b;
         ALU_SUB:   bus.alu_out <= bus.alu_a - bus.alu_b;
         ALU_AND:   bus.alu_out <= bus.alu_a & bus.alu_b;
         ALU_OR:    bus.alu_out <= bus.alu_a | bus.alu_b;
         ALU_XOR:   bus.alu_out <= bus.alu_a ^ bus.alu_b;
         ALU_NOT:   bus.alu_out <= ~bus.alu_a;
         ALU_SHL:   bus.alu_out <= bus.alu_a << 1;
         ALU_SHR:   bus.alu_out <= bus.alu_a >> 1;
         ALU_INC:   bus.alu_out <= bus.alu_a + 8'd1;
         ALU_DEC:   bus.alu_out <= bus.alu_a - 8'd1;
         ALU_PASSA: bus.alu_out <= bus.alu_a;
         ALU_PASSB: bus.alu_out <= bus.alu_b;
         ALU_NAND:  bus.alu_out <= ~(bus.alu_a & bus.alu_b);
         ALU_NOR:   bus.alu_out <= ~(bus.alu_a | bus.alu_b);
         ALU_XNOR:  bus.alu_out <= ~(bus.alu_a ^ bus.alu_b);
         default:   bus.alu_out <= {bus.alu_a[6:0], bus.alu_a[7]};
      endcase
   end

   // Hand-computed results for A=05, B=01, indexed by opcode
   logic [7:0] exp_sweep [16] = '{8'h06, 8'h04, 8'h01, 8'h05, 8'h04, 8'hFA, 8'h0A, 8'h02,
                                  8'h06, 8'h04, 8'h05, 8'h01, 8'hFE, 8'hFA, 8'hFB, 8'h0A};

   // Called at posedge+1; returns at posedge+1 right after the accepting edge
   task automatic send_byte(input logic [7:0] b);
      logic ok;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int i = 0; i < 40; i++) begin
         ok = bus.in_ready;
         @(posedge clk); #1;
         if (ok) begin
            bus.in_valid = 1'b0;
            return;
         end
      end
      bus.in_valid = 1'b0;
      n_vec++; n_err++;
      $display("FAIL send_byte timeout data %h in_ready %b", b, bus.in_ready);
   endtask

   task automatic wait_res();
      for (int i = 0; i < 40; i++) begin
         if (bus.res_valid) return;
         @(posedge clk); #1;
      end
      n_vec++; n_err++;
      $display("FAIL wait_res timeout res_valid %b", bus.res_valid);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %b exp 0", bus.in_ready); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
      n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b exp 0", bus.res_valid); end
      n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data, bus.res_sel, bus.err_count, bus.err_hdr} !== 45'd0) begin
         n_err++; $display("FAIL rst_regs got a %h b %h sel %h rd %h rs %h ec %h eh %b exp all 0",
            bus.alu_a, bus.alu_b, bus.alu_sel, bus.res_data, bus.res_sel, bus.err_count, bus.err_hdr);
      end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready got %b exp 1", bus.in_ready); end
   endtask

   task automatic test_basic_add();
      bus.res_ready = 1'b1;
      send_byte(8'hA0);
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL t1_busy_after_hdr got %b exp 1", bus.busy); end
      send_byte(8'h05);
      send_byte(8'h01);
      n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== {8'h05, 8'h01, 4'h0}) begin
         n_err++; $display("FAIL t1_alu_ops got a %h b %h sel %h exp 05 01 0", bus.alu_a, bus.alu_b, bus.alu_sel);
      end
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL t1_in_ready_wait got %b exp 0", bus.in_ready); end
      @(posedge clk); #1;
      n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL t1_res_valid_early got %b exp 0", bus.res_valid); end
      @(posedge clk); #1;
      n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL t1_res_valid got %b exp 1", bus.res_valid); end
      n_vec++; if ({bus.res_data, bus.res_sel} !== {8'h06, 4'h0}) begin
         n_err++; $display("FAIL t1_result got data %h sel %h exp 06 0", bus.res_data, bus.res_sel);
      end
      @(posedge clk); #1;
      n_vec++; if ({bus.res_valid, bus.busy, bus.in_ready} !== 3'b001) begin
         n_err++; $display("FAIL t1_done got valid %b busy %b ready %b exp 0 0 1", bus.res_valid, bus.busy, bus.in_ready);
      end
   endtask

   task automatic test_bad_header();
      send_byte(8'h30);
      n_vec++; if (bus.err_hdr !== 1'b1) begin n_err++; $display("FAIL t2_err_hdr got %b exp 1", bus.err_hdr); end
      n_vec++; if (bus.err_count !== 8'd1) begin n_err++; $display("FAIL t2_err_count got %0d exp 1", bus.err_count); end
      n_vec++; if ({bus.in_ready, bus.busy} !== 2'b10) begin
         n_err++; $display("FAIL t2_state got ready %b busy %b exp 1 0", bus.in_ready, bus.busy);
      end
      send_byte(8'hA3);
      n_vec++; if (bus.err_hdr !== 1'b0) begin n_err++; $display("FAIL t2_err_hdr_pulse got %b exp 0", bus.err_hdr); end
      send_byte(8'h05);
      send_byte(8'h01);
      wait_res();
      n_vec++; if ({bus.res_data, bus.res_sel} !== {8'h05, 4'h3}) begin
         n_err++; $display("FAIL t2_result got data %h sel %h exp 05 3", bus.res_data, bus.res_sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      bus.res_ready = 1'b0;
      send_byte(8'hA2);
      send_byte(8'h05);
      send_byte(8'h01);
      wait_res();
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA4;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_vec++; if ({bus.res_valid, bus.in_ready, bus.res_data, bus.res_sel} !== {1'b1, 1'b0, 8'h01, 4'h2}) begin
            n_err++; $display("FAIL t3_hold cyc %0d got valid %b ready %b data %h sel %h exp 1 0 01 2",
               i, bus.res_valid, bus.in_ready, bus.res_data, bus.res_sel);
         end
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      n_vec++; if ({bus.res_valid, bus.busy, bus.in_ready} !== 3'b001) begin
         n_err++; $display("FAIL t3_handshake got valid %b busy %b ready %b exp 0 0 1", bus.res_valid, bus.busy, bus.in_ready);
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL t3_next_hdr got busy %b exp 1", bus.busy); end
      send_byte(8'h05);
      send_byte(8'h01);
      wait_res();
      n_vec++; if ({bus.res_data, bus.res_sel} !== {8'h04, 4'h4}) begin
         n_err++; $display("FAIL t3_next_result got data %h sel %h exp 04 4", bus.res_data, bus.res_sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] hdr;
      bus.res_ready = 1'b1;
      for (int op = 0; op < 16; op++) begin
         hdr = 8'hA0 | 8'(op);
         send_byte(hdr);
         send_byte(8'h05);
         send_byte(8'h01);
         wait_res();
         n_vec++; if ({bus.res_data, bus.res_sel} !== {exp_sweep[op], 4'(op)}) begin
            n_err++; $display("FAIL t4_sweep op %0d got data %h sel %h exp %h %h", op, bus.res_data, bus.res_sel, exp_sweep[op], 4'(op));
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midframe();
      send_byte(8'hA1);
      send_byte(8'h05);
      #2 reset = 1'b1;
      #1;
      n_vec++; if ({bus.in_ready, bus.busy, bus.res_valid, bus.alu_a, bus.alu_sel, bus.res_sel, bus.err_count} !== 35'd0) begin
         n_err++; $display("FAIL t5_async_rst got ready %b busy %b valid %b a %h sel %h rs %h ec %0d exp all 0",
            bus.in_ready, bus.busy, bus.res_valid, bus.alu_a, bus.alu_sel, bus.res_sel, bus.err_count);
      end
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         n_vec++; if ({bus.res_valid, bus.busy} !== 2'b00) begin
            n_err++; $display("FAIL t5_idle cyc %0d got valid %b busy %b exp 0 0", i, bus.res_valid, bus.busy);
         end
         @(posedge clk); #1;
      end
      send_byte(8'hA1);
      send_byte(8'h09);
      send_byte(8'h04);
      wait_res();
      n_vec++; if ({bus.res_data, bus.res_sel} !== {8'h05, 4'h1}) begin
         n_err++; $display("FAIL t5_result got data %h sel %h exp 05 1", bus.res_data, bus.res_sel);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_err_saturate();
      int pulses = 0;
      int busy_seen = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h00;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (bus.err_hdr === 1'b1) pulses++;
         if (bus.busy !== 1'b0) busy_seen++;
      end
      bus.in_valid = 1'b0;
      n_vec++; if (bus.err_count !== 8'd255) begin n_err++; $display("FAIL t6_err_count got %0d exp 255", bus.err_count); end
      n_vec++; if (pulses != 300) begin n_err++; $display("FAIL t6_pulses got %0d exp 300", pulses); end
      n_vec++; if (busy_seen != 0) begin n_err++; $display("FAIL t6_busy got %0d busy cycles exp 0", busy_seen); end
      @(posedge clk); #1;
      n_vec++; if ({bus.err_hdr, bus.err_count} !== {1'b0, 8'd255}) begin
         n_err++; $display("FAIL t6_after got err_hdr %b count %0d exp 0 255", bus.err_hdr, bus.err_count);
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.res_ready = 1'b1;
      test_reset();
      test_basic_add();
      test_bad_header();
      test_backpressure();
      test_back_to_back();
      test_reset_midframe();
      test_err_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
